// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M->W pipeline register with load extraction,
// writeback select, misaligned-load flag and retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_w,
    input  logic             flush_w,
    input  logic             valid_m,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    input  logic [4:0]       RdM,
    input  logic [1:0]       ResultSrcM,
    input  logic             RegWriteM,
    input  logic [2:0]       Funct3M,
    output logic             valid_w,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic             load_misalign_w,
    output logic [CNT_W-1:0] instret
);

    logic            valid_r;
    logic            reg_write_r;
    logic [XLEN-1:0] alu_r;
    logic [XLEN-1:0] rdata_r;
    logic [XLEN-1:0] pc4_r;
    logic [4:0]      rd_r;
    logic [1:0]      src_r;
    logic [2:0]      f3_r;
    logic [CNT_W-1:0] count_r;
    logic            retire;

    // A flush overrides a stall, so the held instruction leaves W.
    assign retire = valid_r & (~stall_w | flush_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            alu_r       <= '0;
            rdata_r     <= '0;
            pc4_r       <= '0;
            rd_r        <= '0;
            src_r       <= '0;
            f3_r        <= '0;
            count_r     <= '0;
        end else begin
            if (retire) begin
                count_r <= count_r + 1'b1;
            end
            if (flush_w) begin
                valid_r     <= 1'b0;
                reg_write_r <= 1'b0;
            end else if (!stall_w) begin
                valid_r     <= valid_m;
                reg_write_r <= RegWriteM;
                alu_r       <= ALUResultM;
                rdata_r     <= ReadDataM;
                pc4_r       <= PCPlus4M;
                rd_r        <= RdM;
                src_r       <= ResultSrcM;
                f3_r        <= Funct3M;
            end
        end
    end

    logic [1:0]      addr_lo;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] load_v;
    logic            half_mis;
    logic            word_mis;
    logic            misalign;

    assign addr_lo = alu_r[1:0];

    always_comb begin
        byte_v = rdata_r[7:0];
        unique case (addr_lo)
            2'd0: byte_v = rdata_r[7:0];
            2'd1: byte_v = rdata_r[15:8];
            2'd2: byte_v = rdata_r[23:16];
            2'd3: byte_v = rdata_r[31:24];
        endcase
        half_v = addr_lo[1] ? rdata_r[31:16] : rdata_r[15:0];
    end

    always_comb begin
        load_v = rdata_r;
        case (f3_r)
            3'b000:  load_v = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b001:  load_v = {{(XLEN-16){half_v[15]}}, half_v};
            3'b100:  load_v = {{(XLEN-8){1'b0}}, byte_v};
            3'b101:  load_v = {{(XLEN-16){1'b0}}, half_v};
            default: load_v = rdata_r;
        endcase
    end

    // f3[1]=1 covers LW and the codes treated as LW.
    assign half_mis = (f3_r[1:0] == 2'b01) & addr_lo[0];
    assign word_mis = f3_r[1] & (addr_lo != 2'b00);
    assign misalign = valid_r & (src_r == 2'b01) & (half_mis | word_mis);

    always_comb begin
        ResultW = '0;
        case (src_r)
            2'b00:   ResultW = alu_r;
            2'b01:   ResultW = load_v;
            2'b10:   ResultW = pc4_r;
            default: ResultW = '0;
        endcase
    end

    assign valid_w         = valid_r;
    assign RdW             = rd_r;
    assign load_misalign_w = misalign;
    assign RegWriteW       = valid_r & reg_write_r & (rd_r != 5'd0) & ~misalign;
    assign instret         = count_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage (CNT_W=4 to
// exercise counter wrap).
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_w;
    logic        flush_w;
    logic        valid_m;
    logic [31:0] ALUResultM;
    logic [31:0] ReadDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RdM;
    logic [1:0]  ResultSrcM;
    logic        RegWriteM;
    logic [2:0]  Funct3M;
    logic        valid_w;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        load_misalign_w;
    logic [3:0]  instret;

    mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(valid_m), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .ResultSrcM(ResultSrcM),
        .RegWriteM(RegWriteM), .Funct3M(Funct3M), .valid_w(valid_w),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .load_misalign_w(load_misalign_w), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        mis;
        logic        chk_data;
    } exp_t;

    exp_t     sb[$];
    exp_t     cur;
    logic [3:0] cnt;
    int       checks;
    int       errors;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * a);
        h = w >> (16 * a[1]);
        case (f3)
            3'd0:    return 32'($signed(b[7:0]));
            3'd1:    return 32'($signed(h[15:0]));
            3'd4:    return {24'd0, b[7:0]};
            3'd5:    return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3,
                                     input logic [1:0] a);
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
        if ((f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)
            && a != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic st, input logic fl, input logic vm,
                        input logic rw, input logic [4:0] rd,
                        input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4);
        exp_t e;
        stall_w    = st;
        flush_w    = fl;
        valid_m    = vm;
        RegWriteM  = rw;
        RdM        = rd;
        ResultSrcM = src;
        Funct3M    = f3;
        ALUResultM = alu;
        ReadDataM  = rdata;
        PCPlus4M   = pc4;
        if (cur.valid && (!st || fl)) cnt = cnt + 4'd1;
        if (fl) begin
            e = cur;
            e.valid = 1'b0;
            e.rw = 1'b0;
            e.mis = 1'b0;
            e.chk_data = 1'b0;
        end else if (st) begin
            e = cur;
        end else begin
            e.valid = vm;
            e.rd = rd;
            e.mis = vm && src == 2'b01 && ref_mis(f3, alu[1:0]);
            e.rw = vm && rw && rd != 5'd0 && !e.mis;
            case (src)
                2'b00:   e.res = alu;
                2'b01:   e.res = ref_load(f3, alu[1:0], rdata);
                2'b10:   e.res = pc4;
                default: e.res = 32'd0;
            endcase
            e.chk_data = 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("valid_w", {31'd0, valid_w}, {31'd0, e.valid});
            chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, e.rw});
            chk("misalign", {31'd0, load_misalign_w}, {31'd0, e.mis});
            if (e.chk_data) begin
                chk("RdW", {27'd0, RdW}, {27'd0, e.rd});
                chk("ResultW", ResultW, e.res);
            end
            chk("instret", {28'd0, instret}, {28'd0, cnt});
            cur = e;
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, valid_w}, 32'd0);
        chk({tag, "_rw"}, {31'd0, RegWriteW}, 32'd0);
        chk({tag, "_rd"}, {27'd0, RdW}, 32'd0);
        chk({tag, "_res"}, ResultW, 32'd0);
        chk({tag, "_mis"}, {31'd0, load_misalign_w}, 32'd0);
        chk({tag, "_instret"}, {28'd0, instret}, 32'd0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cur = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1};
        cnt = 4'd0;
    endtask

    localparam logic [31:0] WORD = 32'h80FF7F01;

    initial begin
        checks = 0;
        errors = 0;
        cnt = 4'd0;
        cur = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1};
        rst_n = 1'b0;
        stall_w = 0; flush_w = 0; valid_m = 0; RegWriteM = 0;
        RdM = 0; ResultSrcM = 0; Funct3M = 0;
        ALUResultM = 0; ReadDataM = 0; PCPlus4M = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // get valid_w=1, then reset mid-cycle
        step(0, 0, 1, 1, 5'd7, 2'b00, 3'd0, 32'h55, 0, 0);
        async_reset();

        step(0, 0, 1, 1, 5'd5, 2'b00, 3'd0, 32'h1234, 0, 0);
        chk("alu_res", ResultW, 32'h00001234);
        step(0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 0, 0, 0);
        chk("instret_1", {28'd0, instret}, 32'd1);

        step(0, 0, 1, 1, 5'd1, 2'b01, 3'd0, 32'h2002, WORD, 0);
        chk("lb", ResultW, 32'hFFFFFFFF);
        step(0, 0, 1, 1, 5'd2, 2'b01, 3'd4, 32'h2002, WORD, 0);
        chk("lbu", ResultW, 32'h000000FF);
        step(0, 0, 1, 1, 5'd3, 2'b01, 3'd1, 32'h2002, WORD, 0);
        chk("lh", ResultW, 32'hFFFF80FF);
        step(0, 0, 1, 1, 5'd4, 2'b01, 3'd5, 32'h2000, WORD, 0);
        chk("lhu", ResultW, 32'h00007F01);
        step(0, 0, 1, 1, 5'd6, 2'b01, 3'd2, 32'h2000, WORD, 0);
        chk("lw", ResultW, 32'h80FF7F01);
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 1, 5'd8, 2'b01, 3'(i), 32'h3001 + 32'(i), WORD, 0);

        step(0, 0, 1, 1, 5'd9, 2'b01, 3'd2, 32'h1001, WORD, 0);
        chk("lw_mis", {31'd0, load_misalign_w}, 32'd1);
        step(0, 0, 1, 1, 5'd9, 2'b01, 3'd1, 32'h1003, WORD, 0);
        chk("lh_mis", {31'd0, load_misalign_w}, 32'd1);
        step(0, 0, 1, 1, 5'd9, 2'b01, 3'd0, 32'h1003, WORD, 0);
        chk("lb_nomis", {31'd0, load_misalign_w}, 32'd0);

        step(0, 0, 1, 1, 5'd0, 2'b00, 3'd0, 32'hDEADBEEF, 0, 0);
        chk("x0_rw", {31'd0, RegWriteW}, 32'd0);
        step(0, 0, 1, 1, 5'd10, 2'b11, 3'd0, 32'h77, WORD, 32'h99);

        step(0, 0, 1, 1, 5'd11, 2'b00, 3'd0, 32'hCAFE, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 1, 5'(20 + i), 2'b10, 3'd0, 32'(i), 0, 32'hF0);
        step(0, 0, 1, 1, 5'd12, 2'b00, 3'd0, 32'hBEEF, 0, 0);
        step(1, 1, 1, 1, 5'd13, 2'b00, 3'd0, 32'h1, 0, 0);
        chk("flush_valid", {31'd0, valid_w}, 32'd0);

        step(0, 0, 1, 1, 5'd14, 2'b10, 3'd0, 32'h5, 0, 32'h00000104);
        chk("pc4", ResultW, 32'h00000104);
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom);

        async_reset();
        for (int i = 0; i < 17; i++)
            step(0, 0, 1, 1, 5'd1, 2'b00, 3'd0, 32'(i), 0, 0);
        step(0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 0, 0, 0);
        chk("wrap", {28'd0, instret}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
